l1_mau_arb: RTL
===============

L1_MAU_ARB -- requirements
Module: l1_mau_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default `CORE_ADDR_WIDTH, request address width.
REQ-002 SHALL have parameter DATA_W, default `CORE_DATA_WIDTH, write data width.
REQ-003 SHALL have parameter LINE_W, default `L1_LINE_SIZE, ack (fill) data width.
REQ-004 SHALL have parameter BE_W, default `CORE_BE_WIDTH, byte-enable width.
REQ-005 SHALL have parameter TMO_CYC, default 255, BUSY cycles before the timeout flag sets.
REQ-006 SHALL have port clk  in  1  sole clock, all logic on posedge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports pN_req_val/pN_req_nc/pN_req_we  in  1 each  request from port N (N=0 L1I, N=1 L1D).
REQ-009 SHALL have ports pN_req_addr/pN_req_wdata/pN_req_be  in  ADDR_W/DATA_W/BE_W  request payload.
REQ-010 SHALL have ports pN_req_ack/pN_ack_nc/pN_ack_we  out  1 each  completion to port N.
REQ-011 SHALL have port pN_ack_data  out  LINE_W  returned line data to port N.
REQ-012 SHALL have ports mem_req_val/mem_req_nc/mem_req_we  out  1 each  downstream request.
REQ-013 SHALL have ports mem_req_addr/mem_req_wdata/mem_req_be  out  ADDR_W/DATA_W/BE_W  downstream payload.
REQ-014 SHALL have ports mem_req_ack/mem_ack_nc/mem_ack_we  in  1 each, and mem_ack_data  in  LINE_W  downstream completion.
REQ-015 SHALL have ports busy  out  1, grant_id  out  1, err_tmo  out  1  status.

Function
REQ-016 SHALL implement FSM IDLE/BUSY; one transaction outstanding downstream at a time.
REQ-017 IDLE: if any pN_req_val=1, SHALL select one port, capture its nc/we/addr/wdata/be into registers, set grant_id, go BUSY at next edge.
REQ-018 Selection SHALL be round-robin: single requester wins; both requesting -> port != last_grant wins; last_grant updates on grant.
REQ-019 BUSY: mem_req_* SHALL drive the captured registers, mem_req_val=1 every BUSY cycle until mem_req_ack; latency pN_req_val -> mem_req_val = 1 cycle.
REQ-020 IDLE: mem_req_val SHALL be 0; mem_req_ack in IDLE SHALL be ignored (no pN_req_ack).
REQ-021 On BUSY cycle with mem_req_ack=1: p[grant_id]_req_ack=1 combinationally same cycle, with p[grant_id]_ack_nc/ack_we/ack_data = mem_ack_nc/mem_ack_we/mem_ack_data; FSM -> IDLE.
REQ-022 Non-granted port's req_ack SHALL be 0; pN_ack_data SHALL pass mem_ack_data to both ports (qualified only by req_ack).
REQ-023 Requester SHALL hold req_val and payload until its req_ack; req_val in cycle after ack is a new request, arbitrated in IDLE; minimum spacing ack -> next mem_req_val = 2 cycles.
REQ-024 Payload changes on the granted port during BUSY SHALL NOT affect mem_req_*.
REQ-025 Losing requester SHALL be granted in the next IDLE cycle in which it still requests (no starvation).
REQ-026 busy SHALL be 1 in BUSY, 0 in IDLE.
REQ-027 Timeout counter: cleared on entry to BUSY, +1 per BUSY cycle without ack, saturating at TMO_CYC; on reaching TMO_CYC, err_tmo sets and stays 1 (sticky) until rst; transaction continues waiting.

Reset
REQ-028 On rst=1 at posedge: state IDLE, last_grant=1 (port 0 wins first contention), grant_id=0, counter=0, err_tmo=0, busy=0, mem_req_val=0 from that edge.
REQ-029 Reset mid-BUSY SHALL abandon the transaction; a later mem_req_ack SHALL be ignored per REQ-020.

Verification
REQ-030 p0 only, addr 0x100, rd; mem_req_ack 3 cycles after mem_req_val -> mem_req_val cycle N+1, held 4 cycles, p0_req_ack 1 cycle with mem_ack_data, p1_req_ack=0.
REQ-031 p0,p1 both assert same cycle after reset -> p0 granted first, p1 second; repeated continuous contention -> grants alternate 0,1,0,1.
REQ-032 p1 granted, p1 changes addr 0x200->0x300 while BUSY -> mem_req_addr stays 0x200 until ack.
REQ-033 TMO_CYC=4, no mem_req_ack for 10 cycles -> err_tmo=1 after 4th BUSY cycle, stays 1 after late ack, cleared only by rst.
REQ-034 rst during BUSY then mem_req_ack next cycle -> no pN_req_ack, mem_req_val=0, busy=0.
REQ-035 mem_req_ack pulse in IDLE with no request -> no req_ack on either port, state unchanged.

Source files
------------

// File: rtl/l1_mau_arb.sv
// Round-robin arbiter merging L1I (port 0) and L1D (port 1) requests onto a
// single memory access unit port, one transaction in flight at a time.
`ifndef CORE_ADDR_WIDTH
`define CORE_ADDR_WIDTH 32
`endif
`ifndef CORE_DATA_WIDTH
`define CORE_DATA_WIDTH 32
`endif
`ifndef L1_LINE_SIZE
`define L1_LINE_SIZE 128
`endif
`ifndef CORE_BE_WIDTH
`define CORE_BE_WIDTH 4
`endif

module l1_mau_arb #(
    parameter int ADDR_W  = `CORE_ADDR_WIDTH,
    parameter int DATA_W  = `CORE_DATA_WIDTH,
    parameter int LINE_W  = `L1_LINE_SIZE,
    parameter int BE_W    = `CORE_BE_WIDTH,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_val,
    input  logic              p0_req_nc,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    input  logic [BE_W-1:0]   p0_req_be,
    output logic              p0_req_ack,
    output logic              p0_ack_nc,
    output logic              p0_ack_we,
    output logic [LINE_W-1:0] p0_ack_data,
    input  logic              p1_req_val,
    input  logic              p1_req_nc,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    input  logic [BE_W-1:0]   p1_req_be,
    output logic              p1_req_ack,
    output logic              p1_ack_nc,
    output logic              p1_ack_we,
    output logic [LINE_W-1:0] p1_ack_data,
    output logic              mem_req_val,
    output logic              mem_req_nc,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [BE_W-1:0]   mem_req_be,
    input  logic              mem_req_ack,
    input  logic              mem_ack_nc,
    input  logic              mem_ack_we,
    input  logic [LINE_W-1:0] mem_ack_data,
    output logic              busy,
    output logic              grant_id,
    output logic              err_tmo
);

    localparam int CW = (TMO_CYC < 1) ? 1 : $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] TMO = CW'(TMO_CYC);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              gid_q, gid_d;
    logic              nc_q, nc_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              sel;

    // On contention the port that did not win last time gets the grant.
    assign sel = (p0_req_val & p1_req_val) ? ~last_q : p1_req_val;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gid_d       = gid_q;
        nc_d        = nc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        mem_req_val = 1'b0;
        p0_req_ack  = 1'b0;
        p1_req_ack  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (p0_req_val | p1_req_val) begin
                    state_d = BUSY;
                    gid_d   = sel;
                    last_d  = sel;
                    cnt_d   = '0;
                    nc_d    = sel ? p1_req_nc    : p0_req_nc;
                    we_d    = sel ? p1_req_we    : p0_req_we;
                    addr_d  = sel ? p1_req_addr  : p0_req_addr;
                    wdata_d = sel ? p1_req_wdata : p0_req_wdata;
                    be_d    = sel ? p1_req_be    : p0_req_be;
                end
            end
            BUSY: begin
                mem_req_val = 1'b1;
                if (mem_req_ack) begin
                    p0_req_ack = ~gid_q;
                    p1_req_ack = gid_q;
                    state_d    = IDLE;
                end else begin
                    if (cnt_q != TMO) cnt_d = cnt_q + CW'(1);
                    if (cnt_d == TMO) tmo_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gid_q   <= 1'b0;
            nc_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            nc_q    <= nc_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_req_nc    = nc_q;
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_be    = be_q;
    assign p0_ack_nc     = mem_ack_nc;
    assign p0_ack_we     = mem_ack_we;
    assign p0_ack_data   = mem_ack_data;
    assign p1_ack_nc     = mem_ack_nc;
    assign p1_ack_we     = mem_ack_we;
    assign p1_ack_data   = mem_ack_data;
    assign busy          = (state_q == BUSY);
    assign grant_id      = gid_q;
    assign err_tmo       = tmo_q;

endmodule
